mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Sequencer and arbiter that shares the core's single unified memory between the instruction-fetch port and the data (load/store) port. It replaces the ad-hoc "freeze PC while EX/MEM does a memory op" scheme with an explicit request/ready handshake per port. Memory access time is a configurable number of cycles, which lets slower memory be modelled. A bounded-starvation rule guarantees fetch progress under back-to-back data traffic.

Parameters:
MEM_LATENCY, 1, number of cycles the memory interface is held per access (>=1)
STARVE_LIMIT, 4, maximum consecutive data grants while if_req is pending before fetch is forced (0 = strict data priority)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
if_req  input  1  fetch request, held until if_ready
if_addr  input  32  fetch byte address
if_rdata  output  32  fetched instruction word, registered
if_ready  output  1  one-cycle completion pulse for fetch
d_req  input  1  data request, held until d_ready
d_we  input  1  1 = store, 0 = load
d_func3  input  3  access size/sign (RV32I funct3 encoding)
d_addr  input  32  data byte address
d_wdata  input  32  store data
d_rdata  output  32  load result, registered
d_ready  output  1  one-cycle completion pulse for data
mem_MemRead  output  1  memory read enable
mem_MemWrite  output  1  memory write enable
mem_func3  output  3  memory access size
mem_addr  output  32  memory address
mem_data_in  output  32  memory write data
mem_data_out  input  32  memory read data (combinational read)
busy  output  1  access in progress (state != IDLE)
grant_data  output  1  1 while the current or last grant is the data port

Behaviour:
- Reset: state=IDLE; all outputs 0; starvation counter 0; latched request cleared. A reset during BUSY abandons the access, and no mem_MemWrite is issued in the reset cycle.
- States: IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - Memory outputs are 0 (MemRead, MemWrite, addr, func3, data_in).
  - If d_req and (if_req=0 or starve_cnt<STARVE_LIMIT or STARVE_LIMIT=0): grant data.
  - Else if if_req: grant fetch.
  - On a grant: latch addr, func3, we and wdata; load the latency counter with MEM_LATENCY; go to BUSY. A fetch grant latches func3=3'b010 and we=0.
- BUSY:
  - Drive mem_addr, mem_func3 and mem_data_in from the latch.
  - mem_MemRead=1 for the whole access on loads and fetches.
  - mem_MemWrite=1 only in the final BUSY cycle on stores, so exactly one write per store.
  - Counter decrements each cycle. At count 1: capture mem_data_out into the granted port's rdata register and go to DONE.
- DONE: the granted port's ready=1 for exactly this cycle; memory outputs 0; no arbitration; next state IDLE.
- Timing: request first sampled in IDLE at cycle t; BUSY during t+1..t+MEM_LATENCY; ready in cycle t+MEM_LATENCY+1. Throughput is one access per MEM_LATENCY+2 cycles.
- Held rdata: if_rdata/d_rdata keep their value until the next completion on that port. d_rdata is not updated on stores.
- Starvation counter: increments on each data grant made while if_req=1, saturating at STARVE_LIMIT. It clears on any fetch grant, and also when if_req=0 at arbitration time.
- Simultaneous requests: data wins unless the starvation limit is reached. Exactly one grant per arbitration.
- Request dropped mid-access: the access still completes and the ready pulse is still produced; requesters must not withdraw.
- No alignment checking; the address is passed through unmodified.
- The latch is not updated outside IDLE, so input changes during BUSY are ignored.

Decomposition:
- Shared package (defines):
  - State encodings ST_IDLE=2'd0, ST_BUSY=2'd1, ST_DONE=2'd2.
  - FUNC3_LW=3'b010.
  - Grant encodings GNT_IF=1'b0, GNT_D=1'b1.
- One sub-module, mem_arb_select: combinational priority/starvation decision. Inputs if_req, d_req, starve_cnt; outputs grant_valid and grant_data. The FSM, latency counter and latches stay in the top level.

Test Plan:
- Fetch only, MEM_LATENCY=1, if_addr=0x10, memory word 0x00500093: mem_MemRead=1 only in cycle t+1; if_ready pulses at t+2; if_rdata=0x00500093; busy falls at t+3.
- Store then load, MEM_LATENCY=3: d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, func3=010. Required: mem_MemWrite high for exactly one cycle (t+3); d_ready at t+4. A following load of 0x100 returns d_rdata=0xDEADBEEF.
- Simultaneous if_req and d_req, STARVE_LIMIT=4, d_req held through 6 accesses: grant order D,D,D,D,IF,D,D. if_ready follows the 4th d_ready after MEM_LATENCY+2 cycles.
- STARVE_LIMIT=0 with both requests continuously asserted: fetch is never granted while d_req=1, and starve_cnt stays 0.
- Reset asserted in the final BUSY cycle of a store to 0x200 (old value 0x0): no write occurs; 0x200 still reads 0x0. Next cycle all outputs are 0 and state is IDLE.
- Requester drops d_req mid-access: d_ready still pulses once, and no second grant occurs unless the request is re-asserted.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } grant_e;

  localparam logic [2:0] FUNC3_LW = 3'b010;

  // Access latched at grant time and replayed on the memory bus while BUSY.
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  func3;
    logic        we;
    logic [31:0] wdata;
  } access_t;

  // Width of a counter that must hold values 0..max_val (never narrower than 1 bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, data port and unified-memory bus bundled for the arbiter.
interface mem_port_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;

  logic        d_req;
  logic        d_we;
  logic [2:0]  d_func3;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;

  logic        mem_MemRead;
  logic        mem_MemWrite;
  logic [2:0]  mem_func3;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_func3, d_addr, d_wdata, mem_data_out,
    output if_rdata, if_ready, d_rdata, d_ready,
           mem_MemRead, mem_MemWrite, mem_func3, mem_addr, mem_data_in
  );

  // Requester and memory side.
  modport master (
    output if_req, if_addr, d_req, d_we, d_func3, d_addr, d_wdata, mem_data_out,
    input  if_rdata, if_ready, d_rdata, d_ready,
           mem_MemRead, mem_MemWrite, mem_func3, mem_addr, mem_data_in
  );

endinterface

// File: rtl/mem_port_arbiter_select.sv
// Priority decision between fetch and data: data wins unless fetch has starved too long.
module mem_arb_select
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned SC_W         = cnt_width(STARVE_LIMIT)
) (
  input  logic            if_req,
  input  logic            d_req,
  input  logic [SC_W-1:0] starve_cnt,
  output logic            grant_valid,
  output grant_e          grant_data
);

  localparam logic [SC_W-1:0] LIMIT  = SC_W'(STARVE_LIMIT);
  localparam bit              STRICT = (STARVE_LIMIT == 0);

  logic data_allowed;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    data_allowed = !if_req || STRICT || (starve_cnt < LIMIT);
    grant_valid  = if_req || d_req;
    grant_data   = (d_req && data_allowed) ? GNT_D : GNT_IF;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one unified memory between instruction fetch and load/store with a
// request/ready handshake per port, configurable access latency and bounded fetch starvation.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  output logic                busy,
  output logic                grant_data
);

  localparam int unsigned     CNT_W  = cnt_width(MEM_LATENCY);
  localparam int unsigned     SC_W   = cnt_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LAT   = CNT_W'(MEM_LATENCY);
  localparam logic [SC_W-1:0]  SC_MAX = SC_W'(STARVE_LIMIT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  grant_e            gnt_q, gnt_d;
  access_t           acc_q, acc_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;

  logic              sel_valid;
  grant_e            sel_gnt;
  logic              last_beat;

  mem_arb_select #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .SC_W         (SC_W)
  ) u_select (
    .if_req      (bus.if_req),
    .d_req       (bus.d_req),
    .starve_cnt  (starve_q),
    .grant_valid (sel_valid),
    .grant_data  (sel_gnt)
  );

  assign last_beat = (state_q == ST_BUSY) && (cnt_q == CNT_W'(1));

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      starve_q   <= '0;
      gnt_q      <= GNT_IF;
      acc_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      gnt_q      <= gnt_d;
      acc_q      <= acc_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (sel_valid) state_d = ST_BUSY;
      ST_BUSY: if (last_beat) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbitration, latching and read-data capture.
  always_comb begin
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    gnt_d      = gnt_q;
    acc_d      = acc_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    if (state_q == ST_IDLE) begin
      if (!bus.if_req) begin
        starve_d = '0;
      end
      if (sel_valid) begin
        gnt_d = sel_gnt;
        cnt_d = LAT;
        if (sel_gnt == GNT_D) begin
          acc_d = '{addr: bus.d_addr, func3: bus.d_func3, we: bus.d_we, wdata: bus.d_wdata};
          if (bus.if_req && (starve_q != SC_MAX)) begin
            starve_d = starve_q + SC_W'(1);
          end
        end else begin
          acc_d    = '{addr: bus.if_addr, func3: FUNC3_LW, we: 1'b0, wdata: 32'h0};
          starve_d = '0;
        end
      end
    end else if (state_q == ST_BUSY) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (last_beat) begin
        if (gnt_q == GNT_IF) begin
          if_rdata_d = bus.mem_data_out;
        end else if (!acc_q.we) begin
          d_rdata_d = bus.mem_data_out;
        end
      end
    end
  end

  // Memory strobes are also gated by rst so an access abandoned by reset never writes.
  logic        mem_read, mem_write;
  logic [2:0]  mem_func3;
  logic [31:0] mem_addr, mem_wdata;

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_func3 = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if ((state_q == ST_BUSY) && !rst) begin
      mem_read  = !acc_q.we;
      mem_write = acc_q.we && last_beat;
      mem_func3 = acc_q.func3;
      mem_addr  = acc_q.addr;
      mem_wdata = acc_q.wdata;
    end
  end

  assign bus.mem_MemRead  = mem_read;
  assign bus.mem_MemWrite = mem_write;
  assign bus.mem_func3    = mem_func3;
  assign bus.mem_addr     = mem_addr;
  assign bus.mem_data_in  = mem_wdata;

  assign bus.if_ready = (state_q == ST_DONE) && (gnt_q == GNT_IF);
  assign bus.d_ready  = (state_q == ST_DONE) && (gnt_q == GNT_D);
  assign bus.if_rdata = if_rdata_q;
  assign bus.d_rdata  = d_rdata_q;
  assign busy         = (state_q != ST_IDLE);
  assign grant_data   = (gnt_q == GNT_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiter configurations, each with its own word-wide memory model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus_a ();  // MEM_LATENCY=1, STARVE_LIMIT=4
  mem_port_arbiter_if bus_b ();  // MEM_LATENCY=3, STARVE_LIMIT=4
  mem_port_arbiter_if bus_c ();  // MEM_LATENCY=1, STARVE_LIMIT=0

  logic busy_a, busy_b, busy_c;
  logic gd_a, gd_b, gd_c;

  mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) u_a (
    .clk(clk), .rst(rst), .bus(bus_a), .busy(busy_a), .grant_data(gd_a));
  mem_port_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) u_b (
    .clk(clk), .rst(rst), .bus(bus_b), .busy(busy_b), .grant_data(gd_b));
  mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(0)) u_c (
    .clk(clk), .rst(rst), .bus(bus_c), .busy(busy_c), .grant_data(gd_c));

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] mem_c [256];

  logic        ld_en  = 1'b0;
  logic [1:0]  ld_sel = '0;
  logic [7:0]  ld_idx = '0;
  logic [31:0] ld_val = '0;

  assign bus_a.mem_data_out = mem_a[bus_a.mem_addr[9:2]];
  assign bus_b.mem_data_out = mem_b[bus_b.mem_addr[9:2]];
  assign bus_c.mem_data_out = mem_c[bus_c.mem_addr[9:2]];

  always @(posedge clk) begin
    if (ld_en && ld_sel == 2'd0) mem_a[ld_idx] <= ld_val;
    if (ld_en && ld_sel == 2'd1) mem_b[ld_idx] <= ld_val;
    if (ld_en && ld_sel == 2'd2) mem_c[ld_idx] <= ld_val;
    if (bus_a.mem_MemWrite) mem_a[bus_a.mem_addr[9:2]] <= bus_a.mem_data_in;
    if (bus_b.mem_MemWrite) mem_b[bus_b.mem_addr[9:2]] <= bus_b.mem_data_in;
    if (bus_c.mem_MemWrite) mem_c[bus_c.mem_addr[9:2]] <= bus_c.mem_data_in;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [1:0] sel, input logic [31:0] byte_addr, input logic [31:0] val);
    ld_en  = 1'b1;
    ld_sel = sel;
    ld_idx = byte_addr[9:2];
    ld_val = val;
    @(negedge clk);
    ld_en  = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int     done;
    int     cyc;
    int     d_cnt;
    int     if_cnt;
    int     stamp [7];
    logic   order [7];
    logic   exp_ord [7];
    logic   found;

    exp_ord = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    bus_a.if_req = 0; bus_a.if_addr = 0; bus_a.d_req = 0; bus_a.d_we = 0;
    bus_a.d_func3 = 0; bus_a.d_addr = 0; bus_a.d_wdata = 0;
    bus_b.if_req = 0; bus_b.if_addr = 0; bus_b.d_req = 0; bus_b.d_we = 0;
    bus_b.d_func3 = 0; bus_b.d_addr = 0; bus_b.d_wdata = 0;
    bus_c.if_req = 0; bus_c.if_addr = 0; bus_c.d_req = 0; bus_c.d_we = 0;
    bus_c.d_func3 = 0; bus_c.d_addr = 0; bus_c.d_wdata = 0;

    // Memory contents are loaded while reset is held.
    rst = 1'b1;
    tick();
    preload(2'd0, 32'h10, 32'h0050_0093);
    preload(2'd0, 32'h20, 32'h1111_1111);
    preload(2'd0, 32'h40, 32'h1234_5678);
    preload(2'd0, 32'h80, 32'hAAAA_5555);
    preload(2'd1, 32'h100, 32'h0);
    preload(2'd1, 32'h200, 32'h0);
    preload(2'd2, 32'h0, 32'hCAFE_F00D);
    preload(2'd2, 32'h40, 32'h0BAD_0BAD);

    // Reset state.
    check("rst_busy_a",   busy_a, 0);
    check("rst_gd_a",     gd_a, 0);
    check("rst_ifrdy_a",  bus_a.if_ready, 0);
    check("rst_drdy_b",   bus_b.d_ready, 0);
    check("rst_mrd_a",    bus_a.mem_MemRead, 0);
    check("rst_mwr_b",    bus_b.mem_MemWrite, 0);
    check("rst_maddr_a",  bus_a.mem_addr, 0);
    check("rst_ifrdata_a", bus_a.if_rdata, 0);
    rst = 1'b0;

    // Fetch only, latency 1.
    bus_a.if_req = 1; bus_a.if_addr = 32'h10;
    tick();
    check("f1_mrd_busy",  bus_a.mem_MemRead, 1);
    check("f1_maddr",     bus_a.mem_addr, 32'h10);
    check("f1_func3",     bus_a.mem_func3, 3'b010);
    check("f1_rdy_early", bus_a.if_ready, 0);
    tick();
    check("f1_mrd_done",  bus_a.mem_MemRead, 0);
    check("f1_ifrdy",     bus_a.if_ready, 1);
    check("f1_ifrdata",   bus_a.if_rdata, 32'h0050_0093);
    check("f1_gd",        gd_a, 0);
    bus_a.if_req = 0;
    tick();
    check("f1_busy_fall", busy_a, 0);
    check("f1_rdy_pulse", bus_a.if_ready, 0);

    // Store then load, latency 3.
    bus_b.d_req = 1; bus_b.d_we = 1; bus_b.d_func3 = 3'b010;
    bus_b.d_addr = 32'h100; bus_b.d_wdata = 32'hDEAD_BEEF;
    tick();
    check("st_mwr_t1",   bus_b.mem_MemWrite, 0);
    check("st_mrd_t1",   bus_b.mem_MemRead, 0);
    check("st_gd",       gd_b, 1);
    check("st_maddr",    bus_b.mem_addr, 32'h100);
    tick();
    check("st_mwr_t2",   bus_b.mem_MemWrite, 0);
    tick();
    check("st_mwr_t3",   bus_b.mem_MemWrite, 1);
    check("st_wdata",    bus_b.mem_data_in, 32'hDEAD_BEEF);
    check("st_drdy_t3",  bus_b.d_ready, 0);
    tick();
    check("st_drdy",     bus_b.d_ready, 1);
    check("st_mwr_done", bus_b.mem_MemWrite, 0);
    check("st_mem",      mem_b[64], 32'hDEAD_BEEF);
    check("st_drdata",   bus_b.d_rdata, 0);
    bus_b.d_req = 0;
    tick();
    check("st_rdy_pulse", bus_b.d_ready, 0);
    bus_b.d_req = 1; bus_b.d_we = 0;
    tick();
    check("ld_mrd_t1",   bus_b.mem_MemRead, 1);
    tick();
    tick();
    check("ld_mrd_t3",   bus_b.mem_MemRead, 1);
    check("ld_drdy_t3",  bus_b.d_ready, 0);
    tick();
    check("ld_drdy",     bus_b.d_ready, 1);
    check("ld_drdata",   bus_b.d_rdata, 32'hDEAD_BEEF);
    bus_b.d_req = 0;
    tick();

    // Both ports requesting, starvation limit 4.
    bus_a.if_req = 1; bus_a.if_addr = 32'h20;
    bus_a.d_req = 1; bus_a.d_we = 0; bus_a.d_func3 = 3'b010; bus_a.d_addr = 32'h40;
    done = 0;
    cyc  = 0;
    while (done < 7 && cyc < 60) begin
      tick();
      cyc++;
      if (bus_a.d_ready) begin
        order[done] = 1'b1; stamp[done] = cyc; done++;
      end else if (bus_a.if_ready) begin
        order[done] = 1'b0; stamp[done] = cyc; done++;
        bus_a.if_req = 0;
      end
    end
    bus_a.d_req = 0;
    check("sl4_completions", done, 7);
    for (int i = 0; i < done; i++) begin
      check($sformatf("sl4_order_%0d", i), order[i], exp_ord[i]);
    end
    if (done >= 5) check("sl4_if_gap", stamp[4] - stamp[3], 3);
    check("sl4_ifrdata", bus_a.if_rdata, 32'h1111_1111);
    check("sl4_drdata",  bus_a.d_rdata, 32'h1234_5678);
    tick();

    // Strict data priority: fetch waits until data goes quiet.
    bus_c.if_req = 1; bus_c.if_addr = 32'h0;
    bus_c.d_req = 1; bus_c.d_we = 0; bus_c.d_func3 = 3'b010; bus_c.d_addr = 32'h40;
    d_cnt  = 0;
    if_cnt = 0;
    cyc    = 0;
    while (d_cnt < 5 && cyc < 40) begin
      tick();
      cyc++;
      if (bus_c.if_ready) if_cnt++;
      if (bus_c.d_ready) begin
        d_cnt++;
        if (d_cnt == 5) bus_c.d_req = 0;
      end
    end
    check("sl0_d_grants",  d_cnt, 5);
    check("sl0_if_grants", if_cnt, 0);
    check("sl0_starve",    u_c.starve_q, 0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (bus_c.if_ready) found = 1'b1;
    end
    check("sl0_if_after", found, 1);
    check("sl0_ifrdata",  bus_c.if_rdata, 32'hCAFE_F00D);
    bus_c.if_req = 0;
    tick();

    // Reset in the final BUSY cycle of a store abandons the write.
    bus_b.d_req = 1; bus_b.d_we = 1; bus_b.d_func3 = 3'b010;
    bus_b.d_addr = 32'h200; bus_b.d_wdata = 32'h55AA_55AA;
    tick();
    tick();
    tick();
    check("rb_final_beat", bus_b.mem_MemWrite, 1);
    rst = 1'b1;
    bus_b.d_req = 0;
    #1;
    check("rb_mwr_in_rst", bus_b.mem_MemWrite, 0);
    tick();
    rst = 1'b0;
    check("rb_busy",    busy_b, 0);
    check("rb_gd",      gd_b, 0);
    check("rb_drdy",    bus_b.d_ready, 0);
    check("rb_drdata",  bus_b.d_rdata, 0);
    check("rb_maddr",   bus_b.mem_addr, 0);
    check("rb_mem",     mem_b[128], 0);
    bus_b.d_req = 1; bus_b.d_we = 0;
    tick();
    tick();
    tick();
    tick();
    check("rb_ld_rdy",  bus_b.d_ready, 1);
    check("rb_ld_data", bus_b.d_rdata, 0);
    bus_b.d_req = 0;
    tick();

    // Request withdrawn mid-access; input changes while BUSY are ignored.
    bus_a.d_req = 1; bus_a.d_we = 0; bus_a.d_func3 = 3'b010; bus_a.d_addr = 32'h40;
    tick();
    check("dr_maddr", bus_a.mem_addr, 32'h40);
    bus_a.d_req = 0; bus_a.d_addr = 32'h80;
    tick();
    check("dr_drdy",   bus_a.d_ready, 1);
    check("dr_drdata", bus_a.d_rdata, 32'h1234_5678);
    d_cnt = 0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus_a.d_ready) d_cnt++;
      if (busy_a) found = 1'b1;
    end
    check("dr_no_rdy",   d_cnt, 0);
    check("dr_no_grant", found, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
